mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix-up last.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               qneg;      // product / quotient sign
    logic               rneg;      // remainder sign (dividend sign)
    logic               b_zero;
    logic [WIDTH-1:0]   opnd;      // |a| for multiply, |b| for divide
    logic [2*WIDTH-1:0] work;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sh_hi;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt;
    logic [WIDTH-1:0]   quo, rem;

    assign busy = (state != IDLE);

    always_comb begin
        signed_op = ~op[0];
        abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

        // shift-add: conditionally add multiplicand into the upper half, then shift right
        add_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_nxt   = work[0] ? {add_sum, work[WIDTH-1:1]} : {1'b0, work[2*WIDTH-1:1]};

        // restoring divide: the partial remainder stays below the divisor, so the
        // borrow bit of diff alone decides whether the subtraction is kept
        sh_hi     = work[2*WIDTH-1:WIDTH-1];
        diff      = sh_hi - {1'b0, opnd};
        div_nxt   = diff[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};

        quo       = work[WIDTH-1:0];
        rem       = work[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            b_zero      <= 1'b0;
            opnd        <= '0;
            work        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div      <= op[1];
                        qneg        <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg        <= signed_op & a[WIDTH-1];
                        b_zero      <= (b == '0);
                        opnd        <= op[1] ? abs_b : abs_a;
                        work        <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    work <= is_div ? div_nxt : mul_nxt;
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= qneg ? -work : work;
                    end else if (b_zero) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= qneg ? -quo : quo;
                        hi <= rneg ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit; expected HI/LO/div_by_zero
// go into a scoreboard queue at start and are popped at done.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } res_t;

    res_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk();
        res_t r;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("hi", 64'(hi), 64'(r.hi));
            chk("lo", 64'(lo), 64'(r.lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(r.dbz));
        end
    endtask

    // reference: 64-bit host arithmetic; divide by zero keeps prior HI/LO
    task automatic model(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(ia);
        sb = $signed(ib);
        ua = 64'(ia);
        ub = 64'(ib);
        eh = m_hi;
        el = m_lo;
        ed = 1'b0;
        case (o)
            2'd0: begin p = 64'(sa * sb); {eh, el} = p; end
            2'd1: begin p = ua * ub; {eh, el} = p; end
            2'd2: if (ib == '0) ed = 1'b1;
                  else begin q = sa / sb; r = sa % sb; el = q[W-1:0]; eh = r[W-1:0]; end
            default: if (ib == '0) ed = 1'b1;
                  else begin p = ua / ub; el = p[W-1:0]; p = ua % ub; eh = p[W-1:0]; end
        endcase
    endtask

    // called at a negedge; returns at the negedge where done is high
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                          input logic mt);
        int n, bc, t0;
        op = o; a = ia; b = ib; start = 1'b1; mthi = mt; mtlo = mt;
        exp_q.push_back('{eh, el, ed});
        if (!ed) begin m_hi = eh; m_lo = el; end
        t0 = cyc + 1;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("dbz_clear", 64'(div_by_zero), 64'd0);
        n = 0; bc = 0;
        while (!done && n < 60) begin
            if (busy) bc++;
            @(negedge clock);
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc - t0), 64'd33);
        chk("busy_cycles", 64'(bc), 64'd33);
        pop_chk();
    endtask

    initial begin
        logic [W-1:0] ra, rb, eh, el;
        logic [1:0]   ro;
        logic         ed;
        int           n, t0, dcnt;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clock);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);

        // MTLO: only LO changes, no done
        @(negedge clock);
        a = 32'h1234_5678; mtlo = 1'b1;
        @(negedge clock);
        mtlo = 1'b0;
        m_lo = 32'h1234_5678;
        chk("mtlo_lo", 64'(lo), 64'h1234_5678);
        chk("mtlo_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mtlo_done", 64'(done), 64'd0);
        chk("mtlo_busy", 64'(busy), 64'd0);

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        // divide by zero, with mthi/mtlo raised alongside start (start wins)
        run_op(2'd3, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 1'b1);
        run_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

        // requests while busy are ignored
        @(negedge clock);
        op = 2'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        exp_q.push_back('{32'd0, 32'd15, 1'b0});
        m_hi = 32'd0; m_lo = 32'd15;
        t0 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            n++;
            if (n >= 5 && n <= 10) begin
                start = 1'b1; op = 2'd2; a = 32'd99; b = 32'd7; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0; mthi = 1'b0;
        chk("busy_done_seen", 64'(done), 64'd1);
        chk("busy_latency", 64'(cyc - t0), 64'd33);
        pop_chk();
        // start in the done cycle is accepted at once (latency checked inside)
        run_op(2'd0, 32'h7FFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clock);
        chk("single_done", 64'(done), 64'd0);

        // MTHI and MTLO together
        a = 32'hA5A5_A5A5; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;
        chk("mthilo_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthilo_lo", 64'(lo), 64'hA5A5_A5A5);

        // randomized ops against the model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((ro[1] && i[0]) ? 32'($urandom_range(1, 1000)) : $urandom);
            model(ro, ra, rb, eh, el, ed);
            run_op(ro, ra, rb, eh, el, ed, 1'b0);
        end

        // reset mid-operation
        @(negedge clock);
        op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
